ysyx_24080006_clint_arb: RTL



---
 rtl/ysyx_24080006_clint_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ysyx_24080006_clint_arb.sv
// Round-robin arbiter sharing the single CLINT AXI read port between NUM_REQ masters (optional fixed priority via YSYX_24080006_CLINT_ARB_FIXED_PRIO_EN).
// Latency: +1 cycle on AR for arbitration; the R path is combinational pass-through, and there is at least 1 IDLE cycle between transactions.
// Backpressure: owner rready=0 holds the FSM in R while slave rvalid/rdata pass through; non-owners wait with arvalid pending.
package ysyx_24080006_clint_arb_pkg;
    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } axi_r_s2m_t;
endpackage

module ysyx_24080006_clint_arb
    import ysyx_24080006_clint_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  axi_r_m2s_t [NUM_REQ-1:0]       req_m2s,
    output axi_r_s2m_t [NUM_REQ-1:0]       req_s2m,
    output axi_r_m2s_t                     clint_m2s,
    input  axi_r_s2m_t                     clint_s2m,
    output logic                           grant_vld,
    output logic [IDX_W-1:0]               grant_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] rr_ptr;
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic             r_done;

    assign r_done = (state_q == R) && clint_s2m.rvalid && clint_s2m.rlast
                    && req_m2s[grant_idx_q].rready;

`ifdef YSYX_24080006_CLINT_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr;
        if (r_done) begin
            rr_ptr_d = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_d;
        end
    end
`endif

    // Scan from the far end so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_m2s[idx].arvalid) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        clint_m2s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_s2m[i] = '0;
        end

        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_idx_d = win_idx;
                    state_d     = AR;
                end
            end
            AR: begin
                clint_m2s.arvalid              = req_m2s[grant_idx_q].arvalid;
                clint_m2s.araddr               = req_m2s[grant_idx_q].araddr;
                req_s2m[grant_idx_q].arready   = clint_s2m.arready;
                if (req_m2s[grant_idx_q].arvalid && clint_s2m.arready) begin
                    state_d = R;
                end
            end
            R: begin
                req_s2m[grant_idx_q].rvalid = clint_s2m.rvalid;
                req_s2m[grant_idx_q].rdata  = clint_s2m.rdata;
                req_s2m[grant_idx_q].rlast  = clint_s2m.rlast;
                clint_m2s.rready            = req_m2s[grant_idx_q].rready;
                if (r_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant_vld = (state_q != IDLE);
    assign grant_idx = grant_idx_q;

endmodule
